// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g} from MSB to LSB.
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GUARD = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_LUT [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/hex_to_7seg_ca.sv
// Combinational hex nibble to common-anode (active-low) 7-segment decoder.
module hex_to_7seg_ca
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with guard (all-off) gaps between digits.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int GUARD      = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    load_i,
   input  logic                    blank_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int VW = 4 * NUM_DIGITS;
   localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
   localparam int GW = (GUARD > 1)      ? $clog2(GUARD)      : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SW-1:0] DRV_LAST = SW'(SCAN_DIV - 1);
   localparam logic [GW-1:0] GRD_LAST = GW'(GUARD - 1);
   localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

   state_t                state_q,   state_d;
   logic [DW-1:0]         digit_q,   digit_d;
   logic [SW-1:0]         drv_cnt_q, drv_cnt_d;
   logic [GW-1:0]         grd_cnt_q, grd_cnt_d;

   logic [VW-1:0]         shd_val_q, shd_val_d;
   logic [NUM_DIGITS-1:0] shd_dp_q,  shd_dp_d;
   logic [VW-1:0]         act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0] act_dp_q,  act_dp_d;

   logic [6:0]            seg_q,     seg_d;
   logic                  dp_q,      dp_d;
   logic [NUM_DIGITS-1:0] an_q,      an_d;
   logic                  frame_q,   frame_d;

   logic                  frame_start;
   logic                  frame_end;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic [6:0]            dec_seg;
   logic                  suppress;
   logic                  lit;

   // Scan sequencing: IDLE -> (GUARD -> DRIVE) per digit, wrapping after the last digit.
   always_comb begin
      state_d     = state_q;
      digit_d     = digit_q;
      drv_cnt_d   = drv_cnt_q;
      grd_cnt_d   = grd_cnt_q;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d     = ST_GUARD;
            digit_d     = '0;
            grd_cnt_d   = '0;
            frame_start = 1'b1;
         end
         ST_GUARD: begin
            if (grd_cnt_q == GRD_LAST) begin
               state_d   = ST_DRIVE;
               drv_cnt_d = '0;
            end else begin
               grd_cnt_d = grd_cnt_q + 1'b1;
            end
         end
         ST_DRIVE: begin
            if (drv_cnt_q == DRV_LAST) begin
               state_d   = ST_GUARD;
               grd_cnt_d = '0;
               if (digit_q == DIG_LAST) begin
                  digit_d     = '0;
                  frame_start = 1'b1;
                  frame_end   = 1'b1;
               end else begin
                  digit_d = digit_q + 1'b1;
               end
            end else begin
               drv_cnt_d = drv_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Shadow takes every load; active follows the shadow's next value only at a frame
   // boundary, so a load coinciding with the boundary lands in the active copy directly.
   always_comb begin
      shd_val_d = load_i ? value_i : shd_val_q;
      shd_dp_d  = load_i ? dp_i    : shd_dp_q;
      act_val_d = act_val_q;
      act_dp_d  = act_dp_q;
      if (frame_start) begin
         act_val_d = shd_val_d;
         act_dp_d  = shd_dp_d;
      end
   end

   assign cur_nib = act_val_q[digit_q * 4 +: 4];
   assign cur_dp  = act_dp_q[digit_q];

   hex_to_7seg_ca u_dec (
      .nib_i (cur_nib),
      .seg_o (dec_seg)
   );

`ifdef SEG7_LZB_EN
   logic [NUM_DIGITS-1:0] hi_zero;
   logic                  zero_acc;

   // hi_zero[k]: nibble k and every nibble above it are zero.
   always_comb begin
      zero_acc = 1'b1;
      hi_zero  = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_acc   = zero_acc & (act_val_q[4*k +: 4] == 4'h0);
         hi_zero[k] = zero_acc;
      end
   end

   assign suppress = hi_zero[digit_q] && (digit_q != '0);
`else
   assign suppress = 1'b0;
`endif

   // Output stage: everything registered, derived from the current state.
   always_comb begin
      lit     = (state_q == ST_DRIVE) && !blank_i;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
      an_d    = '1;
      frame_d = frame_end;
      if (lit) begin
         an_d[digit_q] = 1'b0;
         dp_d          = ~cur_dp;
         seg_d         = suppress ? SEG_OFF : dec_seg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         digit_q   <= '0;
         drv_cnt_q <= '0;
         grd_cnt_q <= '0;
         shd_val_q <= '0;
         shd_dp_q  <= '0;
         act_val_q <= '0;
         act_dp_q  <= '0;
         seg_q     <= SEG_OFF;
         dp_q      <= 1'b1;
         an_q      <= '1;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         digit_q   <= digit_d;
         drv_cnt_q <= drv_cnt_d;
         grd_cnt_q <= grd_cnt_d;
         shd_val_q <= shd_val_d;
         shd_dp_q  <= shd_dp_d;
         act_val_q <= act_val_d;
         act_dp_q  <= act_dp_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
         frame_q   <= frame_d;
      end
   end

   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign an_o    = an_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: position-based reference model plus literal checks.
// Honours SEG7_LZB_EN when the design is built with it.
module tb_seg7_scan_ctrl;

   localparam int ND    = 4;
   localparam int SD    = 4;
   localparam int GD    = 1;
   localparam int PH    = GD + SD;
   localparam int FRAME = ND * PH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   value_i = '0;
   logic [3:0]    dp_i = '0;
   logic          load_i = 1'b0;
   logic          blank_i = 1'b0;
   logic [6:0]    seg_o;
   logic          dp_o;
   logic [3:0]    an_o;
   logic          frame_o;

   int checks = 0;
   int errors = 0;

   // Reference model state (written only by run_model)
   int            m_p = 0;
   int            m_f;
   int            m_d;
   int            m_rst_cnt = 0;
   bit            m_valid = 1'b0;
   logic [15:0]   m_shd, m_act;
   logic [3:0]    m_sdp, m_adp;
   logic [6:0]    e_seg;
   logic          e_dp;
   logic [3:0]    e_an;
   logic          e_frame;

   // Frame capture results
   logic [6:0]    cap_seg [ND];
   logic          cap_dp  [ND];
   int            cap_cnt [ND];
   int            cap_dark;
   int            cap_bad;
   logic          cap_frame_end;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .GUARD      (GD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .value_i (value_i),
      .dp_i    (dp_i),
      .load_i  (load_i),
      .blank_i (blank_i),
      .seg_o   (seg_o),
      .dp_o    (dp_o),
      .an_o    (an_o),
      .frame_o (frame_o)
   );

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;
         4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;
         4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the scan position since reset decides everything. Position 0 is the idle
   // cycle; after that each frame is FRAME positions of (guard, drive x SD) per digit.
   task automatic run_model();
      forever begin
         @(posedge clk);
         if (rst) begin
            m_rst_cnt++;
            m_p = 0;
            m_shd = '0; m_sdp = '0; m_act = '0; m_adp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
            m_valid = 1'b1;
         end else begin
            m_f = (m_p == 0) ? -1 : (m_p - 1) % FRAME;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (m_f >= 0 && (m_f % PH) >= GD && !blank_i) begin
               m_d = m_f / PH;
               e_an[m_d] = 1'b0;
               e_seg = ref_seg(m_act[4*m_d +: 4]);
`ifdef SEG7_LZB_EN
               if (m_d > 0 && (m_act >> (4*m_d)) == 16'h0) e_seg = 7'h7F;
`endif
               e_dp = ~m_adp[m_d];
            end
            e_frame = (m_f == FRAME - 1);
            if (m_p == 0 || m_f == FRAME - 1) begin
               m_act = load_i ? value_i : m_shd;
               m_adp = load_i ? dp_i : m_sdp;
            end
            if (load_i) begin
               m_shd = value_i;
               m_sdp = dp_i;
            end
            m_p++;
         end
      end
   endtask

   task automatic run_monitor();
      int cyc = 0;
      int last_fr = -1;
      int seen_rst = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (seen_rst != m_rst_cnt) begin
            seen_rst = m_rst_cnt;
            last_fr = -1;
         end
         if (m_valid) begin
            chk("cycle_model", {19'd0, an_o, seg_o, dp_o, frame_o},
                {19'd0, e_an, e_seg, e_dp, e_frame});
            if (frame_o === 1'b1) begin
               if (last_fr >= 0) chk("frame_period", cyc - last_fr, FRAME);
               last_fr = cyc;
            end
         end
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      load_i  = 1'b1;
      value_i = v;
      dp_i    = dp;
      @(negedge clk);
      load_i  = 1'b0;
   endtask

   task automatic wait_frame(input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (frame_o === 1'b1) found = 1'b1;
      end
      chk("frame_seen", {31'd0, found}, 32'd1);
   endtask

   task automatic wait_an(input logic [3:0] pat, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (an_o === pat) found = 1'b1;
      end
      chk("an_pattern_seen", {31'd0, found}, 32'd1);
   endtask

   // Samples the FRAME cycles following a frame pulse; optionally issues two loads early on.
   task automatic capture_frame(input bit two_loads);
      logic [3:0] msk;
      bit hit;
      for (int d = 0; d < ND; d++) begin
         cap_cnt[d] = 0; cap_seg[d] = 7'h55; cap_dp[d] = 1'b0;
      end
      cap_dark = 0; cap_bad = 0; cap_frame_end = 1'b0;
      for (int i = 1; i <= FRAME; i++) begin
         @(negedge clk);
         if (an_o === 4'hF) begin
            cap_dark++;
         end else begin
            hit = 1'b0;
            for (int d = 0; d < ND; d++) begin
               msk = ~(4'b0001 << d);
               if (an_o === msk) begin
                  cap_cnt[d]++; cap_seg[d] = seg_o; cap_dp[d] = dp_o; hit = 1'b1;
               end
            end
            if (!hit) cap_bad++;
         end
         if (i == FRAME) cap_frame_end = frame_o;
         if (two_loads) begin
            load_i = (i == 1) || (i == 3);
            dp_i   = 4'b0000;
            if (i == 1) value_i = 16'h1111;
            if (i == 3) value_i = 16'h2222;
         end
      end
      load_i = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
      for (int d = 0; d < ND; d++) begin
         chk({tag, "_lit_cycles"}, cap_cnt[d], SD);
         chk({tag, "_seg"}, {25'd0, cap_seg[d]}, {25'd0, segs[7*d +: 7]});
         chk({tag, "_dp"}, {31'd0, cap_dp[d]}, {31'd0, ~dps[d]});
      end
      chk({tag, "_dark_cycles"}, cap_dark, FRAME - ND*SD);
      chk({tag, "_an_onehot"}, cap_bad, 0);
      chk({tag, "_frame_pulse"}, {31'd0, cap_frame_end}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      fork
         run_model();
         run_monitor();
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_an", {28'd0, an_o}, 32'hF);
      chk("rst_seg", {25'd0, seg_o}, 32'h7F);
      chk("rst_dp", {31'd0, dp_o}, 32'd1);
      chk("rst_frame", {31'd0, frame_o}, 32'd0);
      rst = 1'b0;

      // IDLE, first GUARD, first DRIVE of digit 0 showing "0"
      @(negedge clk);
      chk("idle_an", {28'd0, an_o}, 32'hF);
      chk("idle_seg", {25'd0, seg_o}, 32'h7F);
      @(negedge clk);
      chk("guard_an", {28'd0, an_o}, 32'hF);
      chk("guard_dp", {31'd0, dp_o}, 32'd1);
      @(negedge clk);
      chk("first_drive_an", {28'd0, an_o}, 32'hE);
      chk("first_drive_seg", {25'd0, seg_o}, 32'h01);
      chk("first_drive_dp", {31'd0, dp_o}, 32'd1);

      // 0x1A8F with dp on digit 2
      do_load(16'h1A8F, 4'b0100);
      wait_frame(100);
      capture_frame(1'b0);
      check_frame("f1A8F", {7'b1001111, 7'b0001000, 7'b0000000, 7'b0111000}, 4'b0100);

      // Two loads in one frame: current frame untouched, next shows the last one
      capture_frame(1'b1);
      check_frame("f1A8F_during_loads", {7'b1001111, 7'b0001000, 7'b0000000, 7'b0111000}, 4'b0100);
      capture_frame(1'b0);
      check_frame("f2222", {4{7'b0010010}}, 4'b0000);

      do_load(16'h0042, 4'b0000);
      wait_frame(100);
      capture_frame(1'b0);
`ifdef SEG7_LZB_EN
      check_frame("f0042", {7'h7F, 7'h7F, 7'b1001100, 7'b0010010}, 4'b0000);
`else
      check_frame("f0042", {7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010}, 4'b0000);
`endif
      do_load(16'h0000, 4'b0000);
      wait_frame(100);
      capture_frame(1'b0);
`ifdef SEG7_LZB_EN
      check_frame("f0000", {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b0000);
`else
      check_frame("f0000", {4{7'b0000001}}, 4'b0000);
`endif

      // Nonzero active value with all dps lit, then blank mid-frame
      do_load(16'h5A5A, 4'b1111);
      wait_frame(100);
      repeat (7) @(negedge clk);
      blank_i = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("blank_an", {28'd0, an_o}, 32'hF);
         chk("blank_seg", {25'd0, seg_o}, 32'h7F);
         chk("blank_dp", {31'd0, dp_o}, 32'd1);
      end
      blank_i = 1'b0;

      // Reset during digit 2 drive
      wait_an(4'b1011, 100);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_an", {28'd0, an_o}, 32'hF);
      chk("midrst_seg", {25'd0, seg_o}, 32'h7F);
      chk("midrst_dp", {31'd0, dp_o}, 32'd1);
      chk("midrst_frame", {31'd0, frame_o}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_guard_an", {28'd0, an_o}, 32'hF);
      @(negedge clk);
      chk("post_rst_digit0_an", {28'd0, an_o}, 32'hE);
      chk("post_rst_digit0_seg", {25'd0, seg_o}, 32'h01);
      chk("post_rst_digit0_dp", {31'd0, dp_o}, 32'd1);

      // Randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         load_i  = ($urandom_range(0, 7) == 0);
         value_i = 16'($urandom);
         dp_i    = 4'($urandom);
         if ($urandom_range(0, 15) == 0) blank_i = ~blank_i;
         rst     = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk);
      rst = 1'b0; load_i = 1'b0; blank_i = 1'b0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
